charge_controller: RTL and testbench
====================================

Name: charge_controller

Overview:
- Consumes `grid_state` from the grid classifier.
- Drives the EV charging current setpoint and the output contactor.
- Debounces non-critical grid-state changes, ramps current up and down in fixed steps, and derates the current while the grid is unstable.
- Trips to a latched fault on a critical grid, then holds a cooldown before charging may restart.
- Sits between the grid classifier and the power-stage PWM/current loop.

Parameters:
- MAX_SETPOINT, 16'd3200, current setpoint target while grid is NORMAL (ADC units).
- DERATE_SETPOINT, 16'd1600, current setpoint target while grid is UNSTABLE; must be <= MAX_SETPOINT.
- RAMP_STEP, 16'd32, setpoint change per clock while ramping; nonzero.
- DEBOUNCE_CYCLES, 16, consecutive cycles a NORMAL/UNSTABLE change must persist before it is accepted.
- COOLDOWN_CYCLES, 1024, consecutive non-CRITICAL cycles required to leave FAULT.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- grid_state  input  grid_state_t  raw classifier output (GRID_NORMAL / GRID_UNSTABLE / GRID_CRITICAL).
- ev_connected  input  1  vehicle plugged in.
- charge_request  input  1  vehicle/user requests charging.
- current_setpoint  output  16  registered charge current command.
- contactor_en  output  1  registered output contactor close command.
- fault  output  1  registered; high while in FAULT.
- charge_state  output  3  registered FSM state: IDLE=0, RAMP_UP=1, CHARGING=2, DERATE=3, RAMP_DOWN=4, FAULT=5.
- grid_state_stable  output  grid_state_t  debounced grid state.

Behaviour:
- One clock, clk; reset is asynchronous and active-low on reset_n. All state and outputs clear on reset_n low, independent of clk.
- Reset values:
  - current_setpoint=0, contactor_en=0, fault=0, charge_state=IDLE.
  - grid_state_stable=GRID_NORMAL, debounce and cooldown counters=0.
- Debounce:
  - GRID_CRITICAL on grid_state is accepted into grid_state_stable on the next clock edge, with no debounce.
  - A NORMAL/UNSTABLE value that differs from grid_state_stable must be present DEBOUNCE_CYCLES consecutive cycles; it is accepted on the edge ending the last such cycle.
  - Any interruption, including a return to the stable value or an alternating value, restarts the count.
  - Leaving CRITICAL to NORMAL or UNSTABLE is also debounced.
- Target: tgt = MAX_SETPOINT if stable is NORMAL, DERATE_SETPOINT if stable is UNSTABLE.
- Step arithmetic:
  - Up: sp = min(sp+RAMP_STEP, tgt).
  - Down: sp = max(sp-RAMP_STEP, floor), where floor is tgt or 0.
  - Computed with 17-bit intermediates. No wrap or underflow; sp never exceeds MAX_SETPOINT.
- FSM, priority top-down each cycle:
  - Any state, stable==CRITICAL:
    - Go to FAULT; current_setpoint=0, contactor_en=0, fault=1 on that edge. There is no ramp-down.
    - Cooldown counter clears.
  - FAULT:
    - Counter increments each cycle stable!=CRITICAL and clears whenever stable==CRITICAL.
    - When count reaches COOLDOWN_CYCLES, go to IDLE and set fault=0.
  - IDLE:
    - current_setpoint=0, contactor_en=0.
    - If ev_connected && charge_request && stable==NORMAL, go to RAMP_UP and set contactor_en=1. Setpoint stays 0 on that edge.
  - RAMP_UP, CHARGING, DERATE with !ev_connected || !charge_request: go to RAMP_DOWN.
  - RAMP_UP: step up each cycle; when sp equals tgt, go to CHARGING.
  - CHARGING:
    - Hold sp.
    - If tgt<sp, go to DERATE.
    - If tgt>sp (grid recovered to NORMAL), go to RAMP_UP.
  - DERATE: step down toward tgt; when sp equals tgt, go to CHARGING.
  - RAMP_DOWN:
    - Step down toward 0; contactor_en stays 1.
    - The cycle after sp reaches 0, set contactor_en=0 and go to IDLE.
    - A re-asserted request does not abort RAMP_DOWN; charging restarts via IDLE.
- Simultaneous events: CRITICAL outranks request loss, which outranks target change.
- Contactor rule: contactor_en never falls while current_setpoint!=0, except on the FAULT entry edge.
- Reset mid-ramp forces all outputs to reset values immediately, asynchronously.

Test Plan:
- Reset, then ev_connected=1, charge_request=1, grid NORMAL:
  - contactor_en=1 one edge after the request is sampled.
  - current_setpoint counts 32, 64, … and reaches 3200 after 100 steps.
  - charge_state goes 1 then 2.
- While CHARGING at 3200, grid_state=UNSTABLE:
  - Held for 15 cycles then back to NORMAL: no change.
  - Held for 16 cycles: grid_state_stable=UNSTABLE, state 3, setpoint decreases by 32/cycle to 1600, then state 2.
- At 1600 in CHARGING, grid_state=GRID_CRITICAL for 1 cycle:
  - Next edge: setpoint=0, contactor_en=0, fault=1, state 5.
  - IDLE after 16 debounce cycles plus 1024 cooldown cycles.
  - A second CRITICAL pulse at cooldown count 500 restarts the cooldown count.
- Mid-ramp at setpoint 1000, drop charge_request:
  - RAMP_DOWN steps 968 … 8, then 0 (clamped, no underflow).
  - contactor_en=0 on the following edge, state 0.
- Assert reset_n=0 asynchronously mid-CHARGING, between clock edges: all outputs are at reset values before the next edge.
- With grid_state=UNSTABLE stable in IDLE and a request asserted: stays IDLE, contactor_en=0.

Source files
------------

// File: rtl/charge_controller.sv
// charge_controller: debounced grid-aware EV charge current ramp and contactor sequencer
package charge_controller_pkg;
   typedef enum logic [1:0] {GRID_NORMAL = 2'd0, GRID_UNSTABLE = 2'd1, GRID_CRITICAL = 2'd2} grid_state_t;
endpackage

module charge_controller
   import charge_controller_pkg::*;
#(
   parameter logic [15:0] MAX_SETPOINT    = 16'd3200,
   parameter logic [15:0] DERATE_SETPOINT = 16'd1600,
   parameter logic [15:0] RAMP_STEP       = 16'd32,
   parameter int          DEBOUNCE_CYCLES = 16,
   parameter int          COOLDOWN_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset_n,
   input  grid_state_t grid_state,
   input  logic        ev_connected,
   input  logic        charge_request,
   output logic [15:0] current_setpoint,
   output logic        contactor_en,
   output logic        fault,
   output logic [2:0]  charge_state,
   output grid_state_t grid_state_stable
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int CW = $clog2(COOLDOWN_CYCLES + 1);
   typedef enum logic [2:0] {IDLE, RAMP_UP, CHARGING, DERATE, RAMP_DOWN, FAULT} state_t;
   state_t state, state_n;
   grid_state_t stable, cand;
   logic [DW-1:0] deb, deb_n;
   logic [CW-1:0] cool, cool_n, cool_inc;
   logic [15:0] sp, sp_n, tgt, floor_v, up, dn;
   logic [16:0] up_sum, dn_diff;
   logic con, con_n, flt, flt_n, run;
   assign deb_n = (grid_state == cand && deb != '0) ? deb + DW'(1) : DW'(1);
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable <= GRID_NORMAL;
         cand   <= GRID_NORMAL;
         deb    <= '0;
      end else if (grid_state == GRID_CRITICAL) begin
         stable <= GRID_CRITICAL;
         deb    <= '0;
      end else if (grid_state == stable) begin
         deb    <= '0;
      end else if (deb_n == DW'(DEBOUNCE_CYCLES)) begin
         stable <= grid_state;
         deb    <= '0;
      end else begin
         cand   <= grid_state;
         deb    <= deb_n;
      end
   end
   // Saturating 17-bit step arithmetic keeps the setpoint between floor and target.
   assign tgt      = (stable == GRID_NORMAL) ? MAX_SETPOINT : DERATE_SETPOINT;
   assign floor_v  = (state == RAMP_DOWN) ? 16'd0 : tgt;
   assign up_sum   = {1'b0, sp} + {1'b0, RAMP_STEP};
   assign dn_diff  = {1'b0, sp} - {1'b0, RAMP_STEP};
   assign up       = (up_sum >= {1'b0, tgt}) ? tgt : up_sum[15:0];
   assign dn       = (dn_diff[16] || dn_diff[15:0] <= floor_v) ? floor_v : dn_diff[15:0];
   assign cool_inc = cool + CW'(1);
   assign run      = ev_connected && charge_request;
   always_comb begin
      state_n = state;
      sp_n    = sp;
      con_n   = con;
      flt_n   = flt;
      cool_n  = cool;
      if (stable == GRID_CRITICAL) begin
         state_n = FAULT;
         sp_n    = '0;
         con_n   = 1'b0;
         flt_n   = 1'b1;
         cool_n  = '0;
      end else begin
         case (state)
            FAULT: begin
               cool_n = cool_inc;
               if (cool_inc == CW'(COOLDOWN_CYCLES)) begin
                  state_n = IDLE;
                  flt_n   = 1'b0;
                  cool_n  = '0;
               end
            end
            IDLE: begin
               sp_n  = '0;
               con_n = 1'b0;
               if (run && stable == GRID_NORMAL) begin
                  state_n = RAMP_UP;
                  con_n   = 1'b1;
               end
            end
            RAMP_UP, CHARGING, DERATE: begin
               if (!run) state_n = RAMP_DOWN;
               else if (state == CHARGING) state_n = (tgt < sp) ? DERATE : (tgt > sp) ? RAMP_UP : CHARGING;
               else if (state == RAMP_UP && tgt < sp) state_n = DERATE;
               else if (state == DERATE && tgt >= sp) state_n = CHARGING;
               else begin
                  sp_n    = (state == RAMP_UP) ? up : dn;
                  state_n = (sp_n == tgt) ? CHARGING : state;
               end
            end
            RAMP_DOWN: begin
               sp_n    = dn;
               state_n = (sp == '0) ? IDLE : RAMP_DOWN;
               con_n   = (sp != '0);
            end
            default: begin
               state_n = IDLE;
               sp_n    = '0;
               con_n   = 1'b0;
            end
         endcase
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         sp    <= '0;
         con   <= 1'b0;
         flt   <= 1'b0;
         cool  <= '0;
      end else begin
         state <= state_n;
         sp    <= sp_n;
         con   <= con_n;
         flt   <= flt_n;
         cool  <= cool_n;
      end
   end
   assign current_setpoint  = sp;
   assign contactor_en      = con;
   assign fault             = flt;
   assign charge_state      = state;
   assign grid_state_stable = stable;
endmodule

// File: tb/tb_charge_controller.sv
// tb_charge_controller: directed vector table plus multi-cycle sequences for charge_controller
module tb_charge_controller;
   import charge_controller_pkg::*;
   logic clk = 1'b0, reset_n = 1'b0, ev = 1'b0, req = 1'b0;
   grid_state_t gs = GRID_NORMAL;
   logic [15:0] sp1, sp2;
   logic con1, con2, flt1, flt2;
   logic [2:0] st1, st2;
   grid_state_t stab1, stab2;
   int n_chk = 0, n_fail = 0;

   charge_controller u1 (
      .clk(clk), .reset_n(reset_n), .grid_state(gs), .ev_connected(ev), .charge_request(req),
      .current_setpoint(sp1), .contactor_en(con1), .fault(flt1), .charge_state(st1),
      .grid_state_stable(stab1));

   // Small targets that are not multiples of the step exercise the clamps.
   charge_controller #(.MAX_SETPOINT(16'd1000), .DERATE_SETPOINT(16'd500)) u2 (
      .clk(clk), .reset_n(reset_n), .grid_state(gs), .ev_connected(ev), .charge_request(req),
      .current_setpoint(sp2), .contactor_en(con2), .fault(flt2), .charge_state(st2),
      .grid_state_stable(stab2));

   always #5 clk = ~clk;

   typedef struct {
      grid_state_t gs;
      logic ev, req;
      int sp, con, st, stab;
   } vec_t;
   vec_t tbl[10];

   task automatic chk(input string name, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_all(input string name, input int sp, input int con, input int flt, input int st, input int stab);
      chk({name, "_sp"}, int'(sp1), sp);
      chk({name, "_con"}, int'(con1), con);
      chk({name, "_flt"}, int'(flt1), flt);
      chk({name, "_st"}, int'(st1), st);
      chk({name, "_stab"}, int'(stab1), stab);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      ev = 1'b0;
      req = 1'b0;
      gs = GRID_NORMAL;
      step(2);
      reset_n = 1'b1;
   endtask

   initial begin
      tbl[0] = '{GRID_NORMAL,   1'b0, 1'b0,  0, 0, 0, 0};
      tbl[1] = '{GRID_NORMAL,   1'b1, 1'b0,  0, 0, 0, 0};
      tbl[2] = '{GRID_NORMAL,   1'b1, 1'b1,  0, 1, 1, 0};
      tbl[3] = '{GRID_NORMAL,   1'b1, 1'b1, 32, 1, 1, 0};
      tbl[4] = '{GRID_NORMAL,   1'b1, 1'b1, 64, 1, 1, 0};
      tbl[5] = '{GRID_NORMAL,   1'b1, 1'b0, 64, 1, 4, 0};
      tbl[6] = '{GRID_NORMAL,   1'b1, 1'b0, 32, 1, 4, 0};
      tbl[7] = '{GRID_NORMAL,   1'b1, 1'b1,  0, 1, 4, 0};
      tbl[8] = '{GRID_NORMAL,   1'b1, 1'b0,  0, 0, 0, 0};
      tbl[9] = '{GRID_UNSTABLE, 1'b1, 1'b0,  0, 0, 0, 0};

      reset_n = 1'b0;
      step(2);
      chk_all("reset", 0, 0, 0, 0, 0);
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         gs = tbl[i].gs;
         ev = tbl[i].ev;
         req = tbl[i].req;
         step();
         chk($sformatf("vec%0d_sp", i), int'(sp1), tbl[i].sp);
         chk($sformatf("vec%0d_con", i), int'(con1), tbl[i].con);
         chk($sformatf("vec%0d_st", i), int'(st1), tbl[i].st);
         chk($sformatf("vec%0d_stab", i), int'(stab1), tbl[i].stab);
      end

      // Clamped ramp to 1000, then ramp-down with final partial step.
      do_reset();
      ev = 1'b1;
      req = 1'b1;
      step();
      chk("u2_start_con", int'(con2), 1);
      chk("u2_start_st", int'(st2), 1);
      for (int i = 1; i <= 31; i++) begin
         step();
         chk("u2_up_sp", int'(sp2), 32 * i);
      end
      step();
      chk("u2_clamp_sp", int'(sp2), 1000);
      chk("u2_clamp_st", int'(st2), 2);
      req = 1'b0;
      step();
      chk("u2_drop_st", int'(st2), 4);
      chk("u2_drop_sp", int'(sp2), 1000);
      for (int k = 1; k <= 31; k++) begin
         step();
         chk("u2_dn_sp", int'(sp2), 1000 - 32 * k);
      end
      step();
      chk("u2_zero_sp", int'(sp2), 0);
      chk("u2_zero_con", int'(con2), 1);
      chk("u2_zero_st", int'(st2), 4);
      step();
      chk("u2_idle_con", int'(con2), 0);
      chk("u2_idle_st", int'(st2), 0);

      // Full ramp to MAX_SETPOINT.
      do_reset();
      ev = 1'b1;
      req = 1'b1;
      step();
      chk_all("req", 0, 1, 0, 1, 0);
      for (int i = 1; i <= 100; i++) begin
         step();
         chk("ramp_sp", int'(sp1), 32 * i);
         if (i == 99) chk("ramp_st99", int'(st1), 1);
      end
      chk("ramp_st100", int'(st1), 2);

      // 15-cycle glitch is rejected, 16 cycles is accepted and derates.
      gs = GRID_UNSTABLE;
      step(15);
      gs = GRID_NORMAL;
      step();
      chk_all("glitch15", 3200, 1, 0, 2, 0);
      gs = GRID_UNSTABLE;
      step(15);
      chk("deb15_stab", int'(stab1), 0);
      step();
      chk("deb16_stab", int'(stab1), 1);
      chk("deb16_st", int'(st1), 2);
      step();
      chk_all("derate_entry", 3200, 1, 0, 3, 1);
      for (int k = 1; k <= 50; k++) begin
         step();
         chk("derate_sp", int'(sp1), 3200 - 32 * k);
         if (k == 49) chk("derate_st49", int'(st1), 3);
      end
      chk("derate_done_st", int'(st1), 2);

      // Single-cycle critical pulse trips the fault, then debounce plus cooldown.
      gs = GRID_CRITICAL;
      step();
      chk("crit_stab", int'(stab1), 2);
      chk("crit_st_pre", int'(st1), 2);
      gs = GRID_NORMAL;
      req = 1'b0;
      step();
      chk_all("fault_entry", 0, 0, 1, 5, 2);
      step(15);
      chk("fault_deb_stab", int'(stab1), 0);
      step(1023);
      chk("cool_1023_st", int'(st1), 5);
      chk("cool_1023_flt", int'(flt1), 1);
      step();
      chk_all("cool_done", 0, 0, 0, 0, 0);

      // Second pulse mid-cooldown restarts the count.
      gs = GRID_CRITICAL;
      step();
      gs = GRID_NORMAL;
      step();
      chk("f2_st", int'(st1), 5);
      step(515);
      gs = GRID_CRITICAL;
      step();
      gs = GRID_NORMAL;
      step();
      chk("f3_st", int'(st1), 5);
      chk("f3_flt", int'(flt1), 1);
      step(523);
      chk("restart_st", int'(st1), 5);
      step(515);
      chk("restart_1039_st", int'(st1), 5);
      step();
      chk("restart_done_st", int'(st1), 0);
      chk("restart_done_flt", int'(flt1), 0);

      // Unstable grid blocks a start from IDLE.
      gs = GRID_UNSTABLE;
      step(16);
      chk("idle_unstable_stab", int'(stab1), 1);
      ev = 1'b1;
      req = 1'b1;
      step(3);
      chk_all("idle_unstable", 0, 0, 0, 0, 1);

      // Asynchronous reset between edges while derating.
      gs = GRID_NORMAL;
      step(16);
      for (int t = 0; t < 200 && st1 != 3'd2; t++) step();
      chk("reach_charging", int'(st1), 2);
      gs = GRID_UNSTABLE;
      step(27);
      chk("pre_reset_sp", int'(sp1), 2880);
      chk("pre_reset_st", int'(st1), 3);
      #2;
      reset_n = 1'b0;
      #1;
      chk_all("async_reset", 0, 0, 0, 0, 0);
      step();
      reset_n = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
